seq_multiplier_16bits: RTL

//   Sequential 16x16 -> 32-bit shift-add multiplier. It is the consumer of carry_lookahead_16bits:
//   one adder instance accumulates partial products, one iteration per clock.

---
 rtl/seq_multiplier_16bits_pkg.sv | 22 ++
 rtl/seq_multiplier_16bits_cla.sv | 62 ++++++
 rtl/seq_multiplier_16bits.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_multiplier_16bits_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// SIGNED_MULT_EN selects the optional two's-complement operand mode.
package seq_multiplier_16bits_pkg;

    localparam int MULT_W = 16;
    localparam int PROD_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] LAST_STEP = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Magnitude of a 16-bit two's-complement value; 0x8000 stays 0x8000 (read unsigned).
    function automatic logic [MULT_W-1:0] abs16(input logic [MULT_W-1:0] v);
        return v[MULT_W-1] ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/seq_multiplier_16bits_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead unit
// across the group generate/propagate terms.
module carry_lookahead_16bits (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  cg;
    logic [16:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
    end

    // Second-level lookahead: every group carry-in comes straight from cin_i.
    always_comb begin
        cg[0] = cin_i;
        cg[1] = gg[0] | (gp[0] & cin_i);
        cg[2] = gg[1] | (gp[1] & gg[0])
              | (gp[1] & gp[0] & cin_i);
        cg[3] = gg[2] | (gp[2] & gg[1])
              | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin_i);
        cg[4] = gg[3] | (gp[3] & gg[2])
              | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = cg[k];
            for (int j = 0; j < 4; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[16] = cg[4];
    end

    assign sum_o  = p ^ c[15:0];
    assign cout_o = c[16];

endmodule

// File: rtl/seq_multiplier_16bits.sv
// Sequential 16x16 -> 32 shift-add multiplier, one partial product per clock.
// Define SIGNED_MULT_EN to add the sign_mode port for two's-complement operands.
module seq_multiplier_16bits
    import seq_multiplier_16bits_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
`ifdef SIGNED_MULT_EN
    input  logic              sign_mode,
`endif
    output logic              busy,
    output logic              done,
    output logic [2*WIDTH-1:0] product
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [MULT_W-1:0]   mcand_q, mcand_d;
    logic [MULT_W-1:0]   acc_hi_q, acc_hi_d;
    logic [MULT_W-1:0]   acc_lo_q, acc_lo_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                neg_q, neg_d;

    logic [MULT_W-1:0]   addend;
    logic [MULT_W-1:0]   sum;
    logic                cout;
    logic [PROD_W-1:0]   shifted;
    logic                sgn;

    assign addend  = acc_lo_q[0] ? mcand_q : '0;
    assign shifted = {cout, sum, acc_lo_q[MULT_W-1:1]};

    carry_lookahead_16bits u_add (
        .a_i    (acc_hi_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

`ifdef SIGNED_MULT_EN
    assign sgn = sign_mode;
`else
    assign sgn = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    count_d  = '0;
                    acc_hi_d = '0;
                    mcand_d  = sgn ? abs16(a) : a;
                    acc_lo_d = sgn ? abs16(b) : b;
                    neg_d    = sgn & (a[MULT_W-1] ^ b[MULT_W-1]);
                end
            end
            ST_RUN: begin
                acc_hi_d = shifted[PROD_W-1:MULT_W];
                acc_lo_d = shifted[MULT_W-1:0];
                count_d  = count_q + 4'd1;
                if (count_q == LAST_STEP) begin
                    state_d = ST_DONE;
                    prod_d  = neg_q ? (~shifted + 32'd1) : shifted;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign product = prod_q;

endmodule
